// File: rtl/acc_to_bf16_pipe_pkg.sv
// Shared bf16 types and the normalise/round/pack helper.
// Holds format constants, the bf16 struct and the rounding mode enum.
package tpu_fp_pkg;

    localparam int BF16_BIAS   = 127;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_MANT_W = 7;

    typedef struct packed {
        logic                   sign;
        logic [BF16_EXP_W-1:0]  exp;
        logic [BF16_MANT_W-1:0] mant;
    } bf16_t;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    typedef struct packed {
        bf16_t v;
        logic  inexact;
    } cvt_t;

    // norm holds the magnitude with its leading one at bit 63
    // (all zero for a zero input); p is the leading-one position.
    function automatic cvt_t bf16_pack(
        input logic        sgn,
        input logic [63:0] norm,
        input logic [7:0]  p,
        input rnd_mode_e   mode
    );
        cvt_t       r;
        logic [7:0] mant8;
        logic       g;
        logic       s;
        logic       inc;
        r     = '0;
        mant8 = '0;
        g     = norm[55];
        s     = |norm[54:0];
        inc   = (mode == RND_RNE) && g && (s || norm[56]);
        if (norm[63]) begin
            mant8 = {1'b0, norm[62:56]} + {7'd0, inc};
            // a carry out leaves mant8 = 0x80: mant 0, exp + 1
            r.v.sign  = sgn;
            r.v.exp   = 8'(BF16_BIAS) + p + {7'd0, mant8[7]};
            r.v.mant  = mant8[6:0];
            r.inexact = g | s;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_to_bf16_pipe_if.sv
// Valid/ready stream bundle for the accumulator to bf16 converter.
// in_*: accumulator beats + rne_en; out_*: bf16 beats + inexact flags.
interface acc_to_bf16_pipe_if #(
    parameter int IN_W  = 18,
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  rne_en;
    logic [LANES*IN_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*16-1:0]   out_data;
    logic [LANES-1:0]      out_inexact;

    modport master (
        output in_valid, rne_en, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );

    modport slave (
        input  in_valid, rne_en, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/acc_to_bf16_pipe_lzd_tree.sv
// Recursive log-depth leading-zero detector.
// x: W-bit operand; cnt: number of leading zeros (W when x == 0).
module lzd_tree #(
    parameter int W = 18
) (
    input  logic [W-1:0]           x,
    output logic [$clog2(W+1)-1:0] cnt
);
    localparam int CW = $clog2(W + 1);

    if (W == 1) begin : g_leaf
        assign cnt = ~x;
    end else begin : g_node
        localparam int WH = (W + 1) / 2;
        localparam int WL = W - WH;
        localparam int CH = $clog2(WH + 1);
        localparam int CL = $clog2(WL + 1);

        logic [CH-1:0] ch;
        logic [CL-1:0] cl;

        lzd_tree #(.W(WH)) u_hi (.x(x[W-1 -: WH]), .cnt(ch));
        lzd_tree #(.W(WL)) u_lo (.x(x[WL-1:0]),    .cnt(cl));

        // upper half all zero: its count is WH, keep counting below
        assign cnt = (ch == CH'(WH)) ? CW'(WH) + CW'(cl) : CW'(ch);
    end
endmodule

// File: rtl/acc_to_bf16_pipe.sv
// Multi-lane 2-stage signed accumulator to bf16 converter.
// clk, rst_n, flush plain; stream via acc_to_bf16_pipe_if.slave bus.
module acc_to_bf16_pipe
    import tpu_fp_pkg::*;
#(
    parameter int IN_W        = 18,
    parameter int LANES       = 4,
    parameter int DEFAULT_RNE = 1
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    acc_to_bf16_pipe_if.slave bus
);
    localparam int CW  = $clog2(IN_W + 1);
    localparam int PAD = 64 - IN_W;
    localparam rnd_mode_e RST_MODE =
        (DEFAULT_RNE != 0) ? RND_RNE : RND_TRUNC;

    logic      s1_valid;
    logic      s2_valid;
    logic      s1_adv;
    logic      s2_adv;
    logic      s1_load;
    rnd_mode_e s1_mode;

    logic [LANES*16-1:0] nxt_data;
    logic [LANES-1:0]    nxt_inex;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign s1_load      = bus.in_valid && s1_adv && !flush;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= RST_MODE;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_adv)
                s1_valid <= bus.in_valid;
            if (s1_load)
                s1_mode <= bus.rne_en ? RND_RNE : RND_TRUNC;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IN_W-1:0] raw;
        logic [IN_W-1:0] mag;
        logic            sgn;
        logic [CW-1:0]   lz;
        logic [IN_W-1:0] s1_mag;
        logic            s1_sgn;
        logic [CW-1:0]   s1_lz;
        logic [63:0]     norm;
        logic [7:0]      p;
        cvt_t            res;

        assign raw = bus.in_data[k*IN_W +: IN_W];
        assign sgn = raw[IN_W-1];
        // unsigned view: the most negative value maps to 2^(IN_W-1)
        assign mag = sgn ? -raw : raw;

        lzd_tree #(.W(IN_W)) u_lzd (.x(mag), .cnt(lz));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_sgn <= 1'b0;
                s1_mag <= '0;
                s1_lz  <= '0;
            end else if (s1_load) begin
                s1_sgn <= sgn;
                s1_mag <= mag;
                s1_lz  <= lz;
            end
        end

        always_comb begin
            norm = (64'(s1_mag) << PAD) << s1_lz;
            p    = 8'(IN_W - 1) - 8'(s1_lz);
            res  = bf16_pack(s1_sgn, norm, p, s1_mode);
        end

        assign nxt_data[k*16 +: 16] = res.v;
        assign nxt_inex[k]          = res.inexact;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid        <= 1'b0;
            bus.out_data    <= '0;
            bus.out_inexact <= '0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_adv)
                s2_valid <= s1_valid;
            if (s2_adv && s1_valid && !flush) begin
                bus.out_data    <= nxt_data;
                bus.out_inexact <= nxt_inex;
            end
        end
    end
endmodule

// File: tb/tb_acc_to_bf16_pipe.sv
// Directed bench for acc_to_bf16_pipe (18b x4 lanes, 32b x1 lane).
// Hand-computed bf16 vectors, summary line at the end.
module tb_acc_to_bf16_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    acc_to_bf16_pipe_if #(.IN_W(18), .LANES(4)) bus0 ();
    acc_to_bf16_pipe_if #(.IN_W(32), .LANES(1)) bus1 ();

    acc_to_bf16_pipe #(.IN_W(18), .LANES(4), .DEFAULT_RNE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0)
    );
    acc_to_bf16_pipe #(.IN_W(32), .LANES(1), .DEFAULT_RNE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] rep(input logic [17:0] v);
        return {4{v}};
    endfunction

    task automatic send0(input logic [71:0] d, input logic rne);
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        bus0.rne_en   = rne;
        tick();
        bus0.in_valid = 1'b0;
        tick();
    endtask

    logic [63:0] bp_exp [8];
    int          tx;
    int          rx;
    logic        held_v;
    logic [63:0] held_d;
    logic        acc_in;
    logic        acc_out;

    initial begin
        bp_exp[0] = {4{16'h3F80}};
        bp_exp[1] = {4{16'h4000}};
        bp_exp[2] = {4{16'h4040}};
        bp_exp[3] = {4{16'h4080}};
        bp_exp[4] = {4{16'h40A0}};
        bp_exp[5] = {4{16'h40C0}};
        bp_exp[6] = {4{16'h40E0}};
        bp_exp[7] = {4{16'h4100}};

        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus0.rne_en = 1'b1;   bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        bus1.rne_en = 1'b1;   bus1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_data", bus0.out_data, 64'd0);
        chk("rst_inexact", 64'(bus0.out_inexact), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);

        send0({18'h20000, 18'h00000, 18'h3FFFF, 18'h00001}, 1'b1);
        chk("basic_valid", 64'(bus0.out_valid), 64'd1);
        chk("basic_data", bus0.out_data,
            {16'hC800, 16'h0000, 16'hBF80, 16'h3F80});
        chk("basic_inexact", 64'(bus0.out_inexact), 64'd0);
        tick();
        chk("basic_drain", 64'(bus0.out_valid), 64'd0);

        send0({18'd255, 18'd257, 18'd385, 18'd511}, 1'b1);
        chk("rne_data", bus0.out_data,
            {16'h437F, 16'h4380, 16'h43C0, 16'h4400});
        chk("rne_inexact", 64'(bus0.out_inexact), 64'h7);

        send0({18'd255, 18'd257, 18'd385, 18'd511}, 1'b0);
        chk("trunc_data", bus0.out_data,
            {16'h437F, 16'h4380, 16'h43C0, 16'h43FF});
        chk("trunc_inexact", 64'(bus0.out_inexact), 64'h7);

        bus0.in_valid = 1'b1;
        bus0.in_data  = rep(18'd511);
        bus0.rne_en   = 1'b1;
        tick();
        bus0.rne_en   = 1'b0;
        tick();
        bus0.in_valid = 1'b0;
        bus0.rne_en   = 1'b1;
        chk("mode_a", bus0.out_data, {4{16'h4400}});
        tick();
        chk("mode_b_valid", 64'(bus0.out_valid), 64'd1);
        chk("mode_b", bus0.out_data, {4{16'h43FF}});
        tick();

        tx = 0; rx = 0; held_v = 1'b0; held_d = '0;
        for (int c = 0; c < 80 && rx < 8; c++) begin
            bus0.out_ready = ((c % 3) != 1);
            bus0.in_valid  = (tx < 8);
            bus0.in_data   = rep(18'(tx + 1));
            bus0.rne_en    = 1'b1;
            #1;
            chk("bp_in_ready", 64'(bus0.in_ready),
                64'(!((tx - rx) == 2 && !bus0.out_ready)));
            if (held_v) begin
                chk("bp_hold_valid", 64'(bus0.out_valid), 64'd1);
                chk("bp_hold_data", bus0.out_data, held_d);
            end
            if (bus0.out_valid && bus0.out_ready)
                chk("bp_data", bus0.out_data, bp_exp[rx]);
            acc_in  = bus0.in_valid && bus0.in_ready;
            acc_out = bus0.out_valid && bus0.out_ready;
            held_v  = bus0.out_valid && !bus0.out_ready;
            held_d  = bus0.out_data;
            tick();
            if (acc_in) tx++;
            if (acc_out) rx++;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("bp_count", 64'(rx), 64'd8);
        chk("bp_sent", 64'(tx), 64'd8);
        tick();

        bus0.in_valid = 1'b1;
        bus0.in_data  = rep(18'd3);
        tick();
        bus0.in_data  = rep(18'd5);
        tick();
        chk("fl_pre_valid", 64'(bus0.out_valid), 64'd1);
        bus0.out_ready = 1'b0;
        flush          = 1'b1;
        bus0.in_data   = rep(18'd7);
        tick();
        flush          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("fl_out_valid", 64'(bus0.out_valid), 64'd0);
        tick();
        chk("fl_drain", 64'(bus0.out_valid), 64'd0);
        send0(rep(18'd6), 1'b1);
        chk("fl_next_valid", 64'(bus0.out_valid), 64'd1);
        chk("fl_next_data", bus0.out_data, {4{16'h40C0}});
        tick();

        bus0.in_valid = 1'b1;
        bus0.in_data  = rep(18'd2);
        tick();
        bus0.in_data  = rep(18'd4);
        tick();
        bus0.in_valid = 1'b0;
        chk("rs_pre_valid", 64'(bus0.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rs_out_data", bus0.out_data, 64'd0);
        chk("rs_inexact", 64'(bus0.out_inexact), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rs_after_valid", 64'(bus0.out_valid), 64'd0);
        chk("rs_in_ready", 64'(bus0.in_ready), 64'd1);
        tick();
        chk("rs_after2_valid", 64'(bus0.out_valid), 64'd0);

        bus1.in_valid = 1'b1;
        bus1.in_data  = 32'h7FFF_FFFF;
        bus1.rne_en   = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        tick();
        chk("w32_rne_valid", 64'(bus1.out_valid), 64'd1);
        chk("w32_rne_data", 64'(bus1.out_data), 64'h4F00);
        chk("w32_rne_inexact", 64'(bus1.out_inexact), 64'd1);
        bus1.in_valid = 1'b1;
        bus1.rne_en   = 1'b0;
        tick();
        bus1.in_valid = 1'b0;
        tick();
        chk("w32_trunc_data", 64'(bus1.out_data), 64'h4EFF);
        chk("w32_trunc_inexact", 64'(bus1.out_inexact), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
